commit_trace_packetizer: RTL and testbench

//  Hardware producer for the commit-trace stream that the CPU bench logs in software. It captures one retire event
//  per cycle: NOP/branch, REG write, LD, ST or HALT. It tags each record with a sequence number, buffers records in
//  a FIFO, and serialises them as 16-bit words over valid/ready to a trace sink (UART/debug port/bench checker).
//  It sits beside the single-cycle cpu and taps its commit signals.

---
 rtl/trace_pkg.sv | 57 +++++
 rtl/commit_trace_packetizer_if.sv | 31 +++
 rtl/trace_rec_fifo.sv | 77 +++++++
 rtl/commit_trace_packetizer.sv | 193 +++++++++++++++++++
 tb/tb_commit_trace_packetizer.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/trace_pkg.sv
// -----------------------------------------------------------------------------
// trace_pkg
// Shared types and constants for the commit-trace packetizer:
//   - kind codes for a retired instruction (NOP, REG, LD, ST, HALT)
//   - the 64-bit trace record {kind, rd, seq, pc, d0, d1}
//   - the number of 16-bit words each record kind produces on the wire
//   - the serialiser state encoding
// -----------------------------------------------------------------------------
package trace_pkg;

    localparam int SEQ_W  = 9;
    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_REG  = 3'd1,
        K_LD   = 3'd2,
        K_ST   = 3'd3,
        K_HALT = 3'd4
    } kind_e;

    // kind(3) + rd(4) + seq(9) + pc(16) + d0(16) + d1(16) = 64 bits.
    // The top three fields line up exactly with the header word.
    typedef struct packed {
        kind_e             kind;
        logic [3:0]        rd;
        logic [SEQ_W-1:0]  seq;
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] d0;
        logic [WORD_W-1:0] d1;
    } trace_rec_t;

    localparam int WORDS_NOP  = 2;
    localparam int WORDS_REG  = 3;
    localparam int WORDS_LD   = 4;
    localparam int WORDS_ST   = 4;
    localparam int WORDS_HALT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PC,
        S_D0,
        S_D1
    } tx_state_e;

    function automatic logic [2:0] words_per_kind(input kind_e k);
        case (k)
            K_REG:   return 3'(WORDS_REG);
            K_LD:    return 3'(WORDS_LD);
            K_ST:    return 3'(WORDS_ST);
            K_HALT:  return 3'(WORDS_HALT);
            default: return 3'(WORDS_NOP);
        endcase
    endfunction

endpackage

// File: rtl/commit_trace_packetizer_if.sv
// -----------------------------------------------------------------------------
// commit_trace_packetizer_if
// Valid/ready word stream carrying serialised trace records.
//   tx_valid  - tx_data holds a valid word
//   tx_ready  - sink accepts the word (transfer when tx_valid && tx_ready)
//   tx_data   - 16-bit trace word
//   tx_last   - last word of the current record
// master: the packetizer side; slave: the trace sink side.
// -----------------------------------------------------------------------------
interface commit_trace_packetizer_if;

    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_data;
    logic        tx_last;

    modport master (
        output tx_valid,
        output tx_data,
        output tx_last,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        input  tx_last,
        output tx_ready
    );

endinterface

// File: rtl/trace_rec_fifo.sv
// -----------------------------------------------------------------------------
// trace_rec_fifo
// Synchronous FIFO of DEPTH trace records. Storage is a plain array with a
// registered read port: o_rd_data updates on the edge where i_pop is taken and
// then holds, so the consumer can use it directly as its record register.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (pointers/count only)
//   i_push      - write i_wr_data (ignored while full)
//   i_pop       - read next record into o_rd_data (ignored while empty)
//   o_full      - count == DEPTH (registered count)
//   o_empty     - count == 0
// -----------------------------------------------------------------------------
module trace_rec_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_push,
    input  trace_rec_t i_wr_data,
    input  logic       i_pop,
    output trace_rec_t o_rd_data,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    trace_rec_t       r_mem [DEPTH];
    trace_rec_t       r_rd_data;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_rd_data = r_rd_data;

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
        if (w_do_pop) begin
            r_rd_data <= r_mem[r_rd_ptr];
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/commit_trace_packetizer.sv
// -----------------------------------------------------------------------------
// commit_trace_packetizer
// Taps the CPU commit signals, turns each retire event into a sequence-tagged
// record, buffers it and serialises it as 16-bit words on a valid/ready stream.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   i_ev_*            - retire event (valid, pc, regwrite, reg, wdata,
//                       memread, memwrite, addr, mdata, halt)
//   io_tx             - trace word stream (master side)
//   o_overflow        - sticky: at least one event was dropped
//   o_drop_count      - saturating count of dropped events
//   o_done            - HALT record fully transmitted
// -----------------------------------------------------------------------------
module commit_trace_packetizer
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DROP_W = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_ev_valid,
    input  logic [15:0]                i_ev_pc,
    input  logic                       i_ev_regwrite,
    input  logic [3:0]                 i_ev_reg,
    input  logic [15:0]                i_ev_wdata,
    input  logic                       i_ev_memread,
    input  logic                       i_ev_memwrite,
    input  logic [15:0]                i_ev_addr,
    input  logic [15:0]                i_ev_mdata,
    input  logic                       i_ev_halt,
    commit_trace_packetizer_if.master  io_tx,
    output logic                       o_overflow,
    output logic [DROP_W-1:0]          o_drop_count,
    output logic                       o_done
);

    tx_state_e         r_state;
    tx_state_e         w_state_next;
    logic [SEQ_W-1:0]  r_seq;
    logic              r_halted;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;
    logic              r_done;

    trace_rec_t  w_rec;
    trace_rec_t  w_cur;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_push;
    logic        w_drop;
    logic        w_pop;
    logic        w_fire;
    logic        w_tx_valid;
    logic [15:0] w_tx_data;
    logic        w_tx_last;
    logic [2:0]  w_words;

    // Classifier: load wins over plain register write, and halt wins over store.
    always_comb begin
        w_rec      = '0;
        w_rec.kind = K_NOP;
        w_rec.seq  = r_seq;
        w_rec.pc   = i_ev_pc;
        if (i_ev_regwrite && i_ev_memread) begin
            w_rec.kind = K_LD;
            w_rec.rd   = i_ev_reg;
            w_rec.d0   = i_ev_wdata;
            w_rec.d1   = i_ev_addr;
        end else if (i_ev_regwrite) begin
            w_rec.kind = K_REG;
            w_rec.rd   = i_ev_reg;
            w_rec.d0   = i_ev_wdata;
        end else if (i_ev_halt) begin
            w_rec.kind = K_HALT;
        end else if (i_ev_memwrite) begin
            w_rec.kind = K_ST;
            w_rec.d0   = i_ev_addr;
            w_rec.d1   = i_ev_mdata;
        end
    end

    // Once a HALT has made it into the FIFO, the event port goes deaf.
    // Full comes from the registered count, so a same-cycle pop never rescues a push.
    assign w_accept = i_ev_valid && !r_halted;
    assign w_push   = w_accept && !w_full;
    assign w_drop   = w_accept && w_full;

    trace_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push),
        .i_wr_data (w_rec),
        .i_pop     (w_pop),
        .o_rd_data (w_cur),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign w_words = words_per_kind(w_cur.kind);
    assign w_fire  = w_tx_valid && io_tx.tx_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_seq        <= '0;
            r_halted     <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
            r_done       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_seq <= r_seq + 1'b1;
            end
            if (w_push && (w_rec.kind == K_HALT)) begin
                r_halted <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
            if (w_fire && w_tx_last && (w_cur.kind == K_HALT)) begin
                r_done <= 1'b1;
            end
        end
    end

    // Serialiser: outputs are decoded from the state and the held record, so
    // data and last cannot move while a word is stalled.
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_tx_valid   = 1'b0;
        w_tx_data    = '0;
        w_tx_last    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty && !r_done) begin
                    w_pop        = 1'b1;
                    w_state_next = S_HDR;
                end
            end
            S_HDR: begin
                w_tx_valid = 1'b1;
                w_tx_data  = {w_cur.kind, w_cur.rd, w_cur.seq};
                if (io_tx.tx_ready) begin
                    w_state_next = S_PC;
                end
            end
            S_PC: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_cur.pc;
                w_tx_last  = (w_words == 3'd2);
                if (io_tx.tx_ready) begin
                    w_state_next = w_tx_last ? S_IDLE : S_D0;
                end
            end
            S_D0: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_cur.d0;
                w_tx_last  = (w_words == 3'd3);
                if (io_tx.tx_ready) begin
                    w_state_next = w_tx_last ? S_IDLE : S_D1;
                end
            end
            S_D1: begin
                w_tx_valid = 1'b1;
                w_tx_data  = w_cur.d1;
                w_tx_last  = 1'b1;
                if (io_tx.tx_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign io_tx.tx_valid = w_tx_valid;
    assign io_tx.tx_data  = w_tx_data;
    assign io_tx.tx_last  = w_tx_last;
    assign o_overflow     = r_overflow;
    assign o_drop_count   = r_drop_count;
    assign o_done         = r_done;

endmodule

// File: tb/tb_commit_trace_packetizer.sv
// -----------------------------------------------------------------------------
// tb_commit_trace_packetizer
// Directed bench for commit_trace_packetizer. Inputs are driven and outputs
// sampled around the falling edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_commit_trace_packetizer;

    logic        clk;
    logic        rst_n;
    logic        ev_valid;
    logic [15:0] ev_pc;
    logic        ev_regwrite;
    logic [3:0]  ev_reg;
    logic [15:0] ev_wdata;
    logic        ev_memread;
    logic        ev_memwrite;
    logic [15:0] ev_addr;
    logic [15:0] ev_mdata;
    logic        ev_halt;
    logic        overflow;
    logic [7:0]  drop_count;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    commit_trace_packetizer_if tx_if ();

    commit_trace_packetizer #(
        .DEPTH  (8),
        .DROP_W (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ev_valid    (ev_valid),
        .i_ev_pc       (ev_pc),
        .i_ev_regwrite (ev_regwrite),
        .i_ev_reg      (ev_reg),
        .i_ev_wdata    (ev_wdata),
        .i_ev_memread  (ev_memread),
        .i_ev_memwrite (ev_memwrite),
        .i_ev_addr     (ev_addr),
        .i_ev_mdata    (ev_mdata),
        .i_ev_halt     (ev_halt),
        .io_tx         (tx_if),
        .o_overflow    (overflow),
        .o_drop_count  (drop_count),
        .o_done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_event();
        ev_valid    = 1'b0;
        ev_pc       = '0;
        ev_regwrite = 1'b0;
        ev_reg      = '0;
        ev_wdata    = '0;
        ev_memread  = 1'b0;
        ev_memwrite = 1'b0;
        ev_addr     = '0;
        ev_mdata    = '0;
        ev_halt     = 1'b0;
    endtask

    // Called at a falling edge; presents one event for exactly one rising edge.
    task automatic send_event(input logic rw, input logic mr, input logic mw, input logic h,
                              input logic [15:0] pc, input logic [3:0] rg,
                              input logic [15:0] wd, input logic [15:0] ad,
                              input logic [15:0] md);
        ev_valid    = 1'b1;
        ev_regwrite = rw;
        ev_memread  = mr;
        ev_memwrite = mw;
        ev_halt     = h;
        ev_pc       = pc;
        ev_reg      = rg;
        ev_wdata    = wd;
        ev_addr     = ad;
        ev_mdata    = md;
        @(negedge clk);
        clear_event();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        tx_if.tx_ready = 1'b1;
        clear_event();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for one word transfer and checks it. In toggle mode the
    // ready line flips every cycle and any stalled word must already show the
    // expected data and last. waited = idle cycles before the word appeared.
    task automatic recv_word(input string tag, input logic [15:0] exp_d, input logic exp_l,
                             input bit toggle, output int waited);
        bit got;
        bit stalled;
        int guard;
        got     = 1'b0;
        stalled = 1'b0;
        guard   = 0;
        waited  = 0;
        while (!got && guard < 100) begin
            tx_if.tx_ready = toggle ? ~tx_if.tx_ready : 1'b1;
            #1;
            if (tx_if.tx_valid && tx_if.tx_ready) begin
                check_eq({tag, "_data"}, 32'(tx_if.tx_data), 32'(exp_d));
                check_eq({tag, "_last"}, 32'(tx_if.tx_last), 32'(exp_l));
                $display("word %s: data=0x%04h last=%0d", tag, tx_if.tx_data, tx_if.tx_last);
                got = 1'b1;
            end else if (tx_if.tx_valid) begin
                check_eq({tag, "_hold_data"}, 32'(tx_if.tx_data), 32'(exp_d));
                check_eq({tag, "_hold_last"}, 32'(tx_if.tx_last), 32'(exp_l));
                stalled = 1'b1;
            end else begin
                if (stalled) check_eq({tag, "_valid_held"}, 32'(tx_if.tx_valid), 32'd1);
                if (!stalled) waited++;
            end
            @(negedge clk);
            guard++;
        end
        check_eq({tag, "_arrived"}, 32'(got), 32'd1);
    endtask

    task automatic recv_rec(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3, input int n,
                            input bit toggle, output int lat);
        logic [15:0] w [4];
        int dummy;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        w[3] = w3;
        lat  = 0;
        for (int i = 0; i < n; i++) begin
            if (i == 0) recv_word($sformatf("%s_w%0d", tag, i), w[i], (i == n - 1), toggle, lat);
            else        recv_word($sformatf("%s_w%0d", tag, i), w[i], (i == n - 1), toggle, dummy);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_tx_valid"},   32'(tx_if.tx_valid), 32'd0);
        check_eq({tag, "_tx_data"},    32'(tx_if.tx_data),  32'd0);
        check_eq({tag, "_tx_last"},    32'(tx_if.tx_last),  32'd0);
        check_eq({tag, "_overflow"},   32'(overflow),       32'd0);
        check_eq({tag, "_drop_count"}, 32'(drop_count),     32'd0);
        check_eq({tag, "_done"},       32'(done),           32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int dummy;

        // 1. reset, then idle with no events
        rst_n          = 1'b0;
        tx_if.tx_ready = 1'b1;
        clear_event();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("idle_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        end

        // 2. REG: kind1 reg3 seq0 -> 0x2600; header one edge after capture
        send_event(1'b1, 1'b0, 1'b0, 1'b0, 16'h0004, 4'd3, 16'h1234, 16'h0000, 16'h0000);
        recv_rec("reg", 16'h2600, 16'h0004, 16'h1234, 16'h0000, 3, 1'b0, lat);
        check_eq("reg_latency", 32'(lat), 32'd1);

        // 3. LD: kind2 reg5 seq1 -> 0x4A01
        send_event(1'b1, 1'b1, 1'b0, 1'b0, 16'h000A, 4'd5, 16'hBEEF, 16'h0040, 16'h0000);
        recv_rec("ld", 16'h4A01, 16'h000A, 16'hBEEF, 16'h0040, 4, 1'b0, lat);

        // 4. ST seq2 with a stray reg value that must not reach the header -> 0x6002
        send_event(1'b0, 1'b0, 1'b1, 1'b0, 16'h0010, 4'd7, 16'h0000, 16'h0080, 16'h00FF);
        recv_rec("st", 16'h6002, 16'h0010, 16'h0080, 16'h00FF, 4, 1'b1, lat);

        // 5. overflow: with ready low the serialiser holds seq0 and the FIFO
        //    holds seq1..8, so 9 NOPs fit and events 10 and 11 are dropped.
        do_reset();
        tx_if.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            send_event(1'b0, 1'b0, 1'b0, 1'b0, 16'(32'h0100 + 2 * i), 4'd0, 16'h0, 16'h0, 16'h0);
        end
        check_eq("fill_overflow",   32'(overflow),   32'd0);
        check_eq("fill_drop_count", 32'(drop_count), 32'd0);
        for (int i = 9; i < 11; i++) begin
            send_event(1'b0, 1'b0, 1'b0, 1'b0, 16'(32'h0100 + 2 * i), 4'd0, 16'h0, 16'h0, 16'h0);
        end
        check_eq("ovf_overflow",   32'(overflow),   32'd1);
        check_eq("ovf_drop_count", 32'(drop_count), 32'd2);
        for (int i = 0; i < 9; i++) begin
            recv_rec($sformatf("nop%0d", i), 16'(i), 16'(32'h0100 + 2 * i), 16'h0, 16'h0, 2, 1'b0, lat);
        end
        repeat (3) @(negedge clk);
        check_eq("nop_drained_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        check_eq("nop_sticky_overflow",  32'(overflow),       32'd1);

        // 6a. HALT (halt beats memwrite, reg field zeroed) then 3 ignored events
        do_reset();
        tx_if.tx_ready = 1'b0;
        send_event(1'b0, 1'b0, 1'b1, 1'b1, 16'h0020, 4'd9, 16'h0, 16'h0070, 16'h0);
        send_event(1'b1, 1'b0, 1'b0, 1'b0, 16'h0022, 4'd1, 16'h5555, 16'h0, 16'h0);
        send_event(1'b0, 1'b0, 1'b1, 1'b0, 16'h0024, 4'd0, 16'h0, 16'h0090, 16'h0011);
        send_event(1'b0, 1'b0, 1'b0, 1'b0, 16'h0026, 4'd0, 16'h0, 16'h0, 16'h0);
        check_eq("halt_done_early", 32'(done), 32'd0);
        recv_rec("halt", 16'h8000, 16'h0020, 16'h0, 16'h0, 2, 1'b0, lat);
        check_eq("halt_done", 32'(done), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("post_halt_tx_valid", 32'(tx_if.tx_valid), 32'd0);
        end
        check_eq("post_halt_done_held",  32'(done),       32'd1);
        check_eq("post_halt_drop_count", 32'(drop_count), 32'd0);

        // 6b. reset in the middle of an LD record: kind2 reg2 seq0 -> 0x4400
        do_reset();
        send_event(1'b1, 1'b1, 1'b0, 1'b0, 16'h0030, 4'd2, 16'hAAAA, 16'h0050, 16'h0);
        recv_word("ldr_w0", 16'h4400, 1'b0, 1'b0, dummy);
        recv_word("ldr_w1", 16'h0030, 1'b0, 1'b0, dummy);
        check_eq("ldr_midrecord_valid", 32'(tx_if.tx_valid), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst_no_resume", 32'(tx_if.tx_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
